// File: rtl/serdes_pkg.sv
// Definitions shared by both ends of the n-bit serial link:
// state encoding, the bit-counter width and the default bit order.
package serdes_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam bit LSB_FIRST_DEFAULT = 1'b1;

  // Counter spans 0..n-1, so n=2 still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel load handshake and serial frame outputs of the PISO transmitter.
interface piso_serializer_if #(
  parameter int n = 4
);
  logic [n-1:0] D;
  logic         load;
  logic         ready;
  logic         sout;
  logic         sout_valid;
  logic         done;

  modport master (output D, load, input ready, sout, sout_valid, done);
  modport slave  (input D, load, output ready, sout, sout_valid, done);
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: takes an n-bit word on load/ready and
// emits it one bit per clock with sout_valid, pulsing done after the last bit.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int n         = 4,
  parameter bit LSB_FIRST = LSB_FIRST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  piso_serializer_if.slave bus
);

  localparam int            CW       = cnt_width(n);
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

  state_e          state_q, state_d;
  logic [n-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            done_q,  done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shreg_d = bus.D;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          // Last bit: either chain straight into the next word or fall idle.
          done_d = 1'b1;
          if (bus.load) begin
            shreg_d = bus.D;
            cnt_d   = CNT_LAST;
          end else begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          cnt_d   = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come from registers only; load and D never reach them directly.
  assign bus.ready      = (state_q == IDLE) || (cnt_q == '0);
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.sout       = (state_q == SHIFT) &&
                          (LSB_FIRST ? shreg_q[0] : shreg_q[n-1]);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an n=4 LSB-first and an n=8 MSB-first instance,
// checked every cycle against a frame-level model plus directed literal frames.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.n(4)) bus4 ();
  piso_serializer_if #(.n(8)) bus8 ();

  piso_serializer #(.n(4), .LSB_FIRST(1'b1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  piso_serializer #(.n(8), .LSB_FIRST(1'b0)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: a frame is a word plus the number of its bits still to be sent.
  int          rem4 = 0, rem8 = 0;
  logic [7:0]  word4 = '0, word8 = '0;
  bit          done4 = 0, done8 = 0;

  function automatic bit exp_bit(input logic [7:0] w, input int width,
                                 input bit lsbf, input int rem);
    int k;
    if (rem == 0) return 1'b0;
    k = width - rem;
    return lsbf ? w[k] : w[width-1-k];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem4 = 0; rem8 = 0; done4 = 0; done8 = 0;
    end else begin
      bit acc4, acc8;
      acc4  = bus4.load && (rem4 <= 1);
      acc8  = bus8.load && (rem8 <= 1);
      done4 = (rem4 == 1);
      done8 = (rem8 == 1);
      if (rem4 > 0) rem4--;
      if (rem8 > 0) rem8--;
      if (acc4) begin word4 = {4'h0, bus4.D}; rem4 = 4; end
      if (acc8) begin word8 = bus8.D; rem8 = 8; end
    end
  end

  always @(negedge clk) begin
    chk("m4_sout",  bus4.sout,       exp_bit(word4, 4, 1'b1, rem4));
    chk("m4_valid", bus4.sout_valid, rem4 > 0);
    chk("m4_ready", bus4.ready,      rem4 <= 1);
    chk("m4_done",  bus4.done,       done4);
    chk("m8_sout",  bus8.sout,       exp_bit(word8, 8, 1'b0, rem8));
    chk("m8_valid", bus8.sout_valid, rem8 > 0);
    chk("m8_ready", bus8.ready,      rem8 <= 1);
    chk("m8_done",  bus8.done,       done8);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk4(input string name, input logic s, input logic v,
                      input logic r, input logic d);
    chk({name, "_sout"},  bus4.sout,       s);
    chk({name, "_valid"}, bus4.sout_valid, v);
    chk({name, "_ready"}, bus4.ready,      r);
    chk({name, "_done"},  bus4.done,       d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] bits4;
    logic [7:0] bits8;
    bus4.load = 1'b0; bus4.D = '0;
    bus8.load = 1'b0; bus8.D = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset and idle.
    repeat (10) begin
      step();
      chk4("idle", 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Single frame 4'b1011, LSB first: 1,1,0,1.
    bits4 = 4'b1011;
    bus4.D = bits4; bus4.load = 1'b1;
    step(); bus4.load = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk4("single", bits4[j], 1'b1, j == 3, 1'b0);
      step();
    end
    chk4("single_end", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk4("single_after", 1'b0, 1'b0, 1'b1, 1'b0);

    // MSB first, 8'hA5: 1,0,1,0,0,1,0,1.
    bits8 = 8'b1010_0101;
    bus8.D = 8'hA5; bus8.load = 1'b1;
    step(); bus8.load = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("msb_sout", bus8.sout, bits8[7-j]);
      chk("msb_done", bus8.done, 1'b0);
      step();
    end
    chk("msb_done_end", bus8.done, 1'b1);
    chk("msb_valid_end", bus8.sout_valid, 1'b0);

    // Back-to-back 4'hF then 4'h0.
    step();
    bus4.D = 4'hF; bus4.load = 1'b1;
    step(); bus4.load = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk4("b2b", j < 4, 1'b1, (j == 3) || (j == 7), j == 4);
      if (j == 3) begin bus4.D = 4'h0; bus4.load = 1'b1; end
      if (j == 4) bus4.load = 1'b0;
      step();
    end
    chk4("b2b_end", 1'b0, 1'b0, 1'b1, 1'b1);

    // Ignored load of 4'h3 in the middle of frame 4'hC: 0,0,1,1 only.
    step();
    bus4.D = 4'hC; bus4.load = 1'b1;
    step(); bus4.load = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk4("ign", j >= 2, 1'b1, j == 3, 1'b0);
      if (j == 1) begin bus4.D = 4'h3; bus4.load = 1'b1; end
      if (j == 2) begin bus4.load = 1'b0; bus4.D = 4'h0; end
      step();
    end
    for (int j = 0; j < 4; j++) begin
      chk4("ign_idle", 1'b0, 1'b0, 1'b1, j == 0);
      step();
    end

    // Reset in the middle of frame 4'h6.
    bus4.D = 4'h6; bus4.load = 1'b1;
    step(); bus4.load = 1'b0;
    step();
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk4("rst_now", 1'b0, 1'b0, 1'b1, 1'b0);
    step(); rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk4("rst_idle", 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    bits4 = 4'b1001;
    bus4.D = bits4; bus4.load = 1'b1;
    step(); bus4.load = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk4("post_rst", bits4[j], 1'b1, j == 3, 1'b0);
      step();
    end
    chk4("post_rst_end", 1'b0, 1'b0, 1'b1, 1'b1);

    // Random traffic on both instances, with occasional mid-stream resets.
    for (int c = 0; c < 2000; c++) begin
      if (!rst_n) rst_n = 1'b1;
      bus4.load = ($urandom_range(0, 9) < 4);
      bus4.D    = 4'($urandom);
      bus8.load = ($urandom_range(0, 9) < 4);
      bus8.D    = 8'($urandom);
      if ($urandom_range(0, 199) == 0) #2 rst_n = 1'b0;
      step();
    end
    rst_n = 1'b1;
    bus4.load = 1'b0; bus8.load = 1'b0;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
